// File: rtl/local_memory_seq_pkg.sv
// local_memory_seq_pkg: shared defaults (global.h values) and the read-tag record for the local_memory sequencer
package local_memory_seq_pkg;
  localparam int W_WIDTH_DEF = 16;
  localparam int W_ADDR_DEF = 10;
  localparam int RD_LAT_DEF = 2;
  typedef struct packed {
    logic valid;
    logic last;
  } tag_t;
endpackage

// File: rtl/local_memory_seq_if.sv
// local_memory_seq_if: write stream, scan command/result stream and local_memory port bundle; slave = sequencer, master = its environment
interface local_memory_seq_if
  import local_memory_seq_pkg::*;
#(
  parameter int W_WIDTH = W_WIDTH_DEF,
  parameter int W_ADDR = W_ADDR_DEF
);
  logic wr_valid;
  logic wr_ready;
  logic [W_WIDTH-1:0] wr_data;
  logic wr_load;
  logic [W_ADDR-1:0] wr_base;
  logic rd_start;
  logic [W_ADDR-1:0] rd_base;
  logic [W_ADDR:0] rd_len;
  logic rd_busy;
  logic rd_out_valid;
  logic [W_WIDTH-1:0] rd_out_data;
  logic rd_done;
  logic [W_WIDTH-1:0] mem_data;
  logic [W_ADDR-1:0] mem_wraddress;
  logic mem_wren;
  logic [W_ADDR-1:0] mem_rdaddress;
  logic mem_q;
  modport slave (
    input wr_valid, wr_data, wr_load, wr_base, rd_start, rd_base, rd_len, mem_q,
    output wr_ready, rd_busy, rd_out_valid, rd_out_data, rd_done,
    output mem_data, mem_wraddress, mem_wren, mem_rdaddress
  );
  modport master (
    output wr_valid, wr_data, wr_load, wr_base, rd_start, rd_base, rd_len, mem_q,
    input wr_ready, rd_busy, rd_out_valid, rd_out_data, rd_done,
    input mem_data, mem_wraddress, mem_wren, mem_rdaddress
  );
endinterface

// File: rtl/local_memory_bitpack.sv
// local_memory_bitpack: packs tagged q bits LSB-first into words; ports clk/rst_n, bit_in/valid/last in, out_valid/out_data out
module local_memory_bitpack
  import local_memory_seq_pkg::*;
#(
  parameter int W_WIDTH = W_WIDTH_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic bit_in,
  input  logic valid,
  input  logic last,
  output logic out_valid,
  output logic [W_WIDTH-1:0] out_data
);
  localparam int CW = (W_WIDTH > 1) ? $clog2(W_WIDTH) : 1;
  logic [CW-1:0] count;
  logic [W_WIDTH-1:0] acc;
  logic [W_WIDTH-1:0] word;
  logic emit;
  assign word = acc | (W_WIDTH'(bit_in) << count);
  assign emit = valid && (count == CW'(W_WIDTH - 1) || last);
  // acc is cleared on every emit, so a short final word comes out zero-padded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      acc <= '0;
      out_valid <= 1'b0;
      out_data <= '0;
    end else begin
      out_valid <= emit;
      if (emit) out_data <= word;
      if (valid) begin
        acc <= emit ? '0 : word;
        count <= emit ? '0 : count + CW'(1);
      end
    end
  end
endmodule

// File: rtl/local_memory_seq.sv
// local_memory_seq: write-stream to RAM writes plus range scan of q bits into packed words; ports clk, rst_n, bus (slave)
module local_memory_seq
  import local_memory_seq_pkg::*;
#(
  parameter int W_WIDTH = W_WIDTH_DEF,
  parameter int W_ADDR = W_ADDR_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input logic clk,
  input logic rst_n,
  local_memory_seq_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SETUP = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;
  logic [1:0] state;
  logic [1:0] state_nx;
  logic [W_ADDR-1:0] wr_ptr;
  logic [W_ADDR-1:0] base_q;
  logic [W_ADDR:0] rem;
  logic rem_one;
  logic start;
  logic hs;
  logic busy;
  logic scan_done;
  logic empty_done;
  tag_t tag_in;
  tag_t tag_out;
  tag_t pipe [RD_LAT];
  assign start = state == IDLE && bus.rd_start;
  assign rem_one = rem == (W_ADDR + 1)'(1);
  assign hs = bus.wr_valid && bus.wr_ready;
  assign tag_out = pipe[RD_LAT-1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = (bus.rd_start && bus.rd_len != '0) ? SETUP : IDLE;
      SETUP: state_nx = ISSUE;
      ISSUE: state_nx = rem_one ? DRAIN : ISSUE;
      DRAIN: state_nx = tag_out.last ? IDLE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  // wr_ready is gated by rst_n so every output reads 0 while reset is held
  always_comb begin
    busy = state != IDLE || scan_done;
    bus.rd_busy = busy;
    bus.wr_ready = rst_n && !busy;
    bus.rd_done = scan_done || empty_done;
    tag_in.valid = state == ISSUE;
    tag_in.last = state == ISSUE && rem_one;
  end
  // a load in the handshake cycle redirects the word to wr_base
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      bus.mem_wren <= 1'b0;
      bus.mem_data <= '0;
      bus.mem_wraddress <= '0;
    end else begin
      bus.mem_wren <= hs;
      if (hs) begin
        bus.mem_data <= bus.wr_data;
        bus.mem_wraddress <= bus.wr_load ? bus.wr_base : wr_ptr;
      end
      if (bus.wr_load || hs) wr_ptr <= (bus.wr_load ? bus.wr_base : wr_ptr) + W_ADDR'(hs);
    end
  end
  // the address is loaded in SETUP so a write accepted alongside rd_start lands before the first read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      rem <= '0;
      bus.mem_rdaddress <= '0;
      scan_done <= 1'b0;
      empty_done <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      empty_done <= start && bus.rd_len == '0;
      scan_done <= tag_out.last;
      pipe[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
      if (start) begin
        base_q <= bus.rd_base;
        rem <= bus.rd_len;
      end
      if (state == SETUP) bus.mem_rdaddress <= base_q;
      if (state == ISSUE) begin
        rem <= rem - (W_ADDR + 1)'(1);
        if (!rem_one) bus.mem_rdaddress <= bus.mem_rdaddress + W_ADDR'(1);
      end
    end
  end
  local_memory_bitpack #(.W_WIDTH(W_WIDTH)) u_bitpack (
    .clk(clk),
    .rst_n(rst_n),
    .bit_in(bus.mem_q),
    .valid(tag_out.valid),
    .last(tag_out.last),
    .out_valid(bus.rd_out_valid),
    .out_data(bus.rd_out_data)
  );
endmodule

// File: tb/tb_local_memory_seq.sv
// tb_local_memory_seq: self-checking bench with a RAM model behind the sequencer and a reference memory/scan model
module tb_local_memory_seq;
  localparam int W = 16;
  localparam int A = 10;
  localparam int L = 2;
  localparam int D = 1 << A;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  local_memory_seq_if #(.W_WIDTH(W), .W_ADDR(A)) bus ();
  local_memory_seq #(.W_WIDTH(W), .W_ADDR(A), .RD_LAT(L)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );
  logic [W-1:0] ram [D];
  logic [L-1:0] qp;
  always @(posedge clk) begin
    qp <= {qp[L-2:0], ram[bus.mem_rdaddress][0]};
    if (bus.mem_wren) ram[bus.mem_wraddress] <= bus.mem_data;
  end
  assign bus.mem_q = qp[L-1];
  int n_chk = 0;
  int n_fail = 0;
  logic [W-1:0] ref_mem [D];
  logic [A-1:0] ref_ptr = '0;
  logic [A-1:0] last_rd = '0;
  typedef struct {
    logic ld;
    logic [A-1:0] b;
    logic v;
    logic [W-1:0] d;
    logic e_wren;
    logic [A-1:0] e_addr;
  } vec_t;
  vec_t tbl [8];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive_idle;
    bus.wr_valid = 1'b0;
    bus.wr_load = 1'b0;
    bus.rd_start = 1'b0;
  endtask
  task automatic model_wr(input logic ld, input logic [A-1:0] b, input logic [W-1:0] d);
    if (ld) ref_ptr = b;
    ref_mem[ref_ptr] = d;
    ref_ptr = ref_ptr + A'(1);
  endtask
  task automatic put(input logic ld, input logic [A-1:0] b, input logic [W-1:0] d);
    bus.wr_load = ld;
    bus.wr_base = b;
    bus.wr_valid = 1'b1;
    bus.wr_data = d;
    model_wr(ld, b, d);
    tick();
  endtask
  task automatic check_all_zero(input string tag);
    chk({tag, " wr_ready"}, bus.wr_ready, 0);
    chk({tag, " rd_busy"}, bus.rd_busy, 0);
    chk({tag, " rd_out_valid"}, bus.rd_out_valid, 0);
    chk({tag, " rd_out_data"}, bus.rd_out_data, 0);
    chk({tag, " rd_done"}, bus.rd_done, 0);
    chk({tag, " mem_data"}, bus.mem_data, 0);
    chk({tag, " mem_wraddress"}, bus.mem_wraddress, 0);
    chk({tag, " mem_wren"}, bus.mem_wren, 0);
    chk({tag, " mem_rdaddress"}, bus.mem_rdaddress, 0);
  endtask
  // expected words come straight from the reference memory: bit k of a group is the LSB at base+k
  task automatic scan(input logic [A-1:0] b, input int ln, input bit ww, input bit hold, input logic [W-1:0] wd);
    logic [W-1:0] ew [$];
    int ec [$];
    int last;
    bit busy_e;
    bit v_e;
    bit wren_e;
    int k;
    logic [A-1:0] wa;
    logic [A-1:0] wa2;
    logic [A-1:0] ra;
    wa = '0;
    wa2 = '0;
    bus.rd_start = 1'b1;
    bus.rd_base = b;
    bus.rd_len = (A + 1)'(ln);
    if (ww) begin
      bus.wr_valid = 1'b1;
      bus.wr_load = 1'b0;
      bus.wr_data = wd;
      wa = ref_ptr;
      model_wr(1'b0, '0, wd);
    end
    for (int i = 0; i < ln; i += W) begin
      logic [W-1:0] w;
      int n;
      w = '0;
      n = (ln - i < W) ? ln - i : W;
      for (int j = 0; j < n; j++) w[j] = ref_mem[(int'(b) + i + j) % D][0];
      ew.push_back(w);
      ec.push_back(2 + i + n + L);
    end
    last = (ln == 0) ? 1 : 2 + ln + L;
    tick();
    bus.rd_start = 1'b0;
    if (!hold) bus.wr_valid = 1'b0;
    for (int c = 1; c <= last + 2; c++) begin
      busy_e = ln != 0 && c <= last;
      chk("rd_busy", bus.rd_busy, busy_e);
      chk("wr_ready", bus.wr_ready, !busy_e);
      chk("rd_done", bus.rd_done, c == last);
      v_e = ec.size() > 0 && ec[0] == c;
      chk("rd_out_valid", bus.rd_out_valid, v_e);
      if (v_e) begin
        chk("rd_out_data", bus.rd_out_data, ew[0]);
        void'(ew.pop_front());
        void'(ec.pop_front());
      end
      wren_e = (c == 1 && ww) || (hold && c == last + 2);
      chk("mem_wren", bus.mem_wren, wren_e);
      if (c == 1 && ww) chk("mem_wraddress start-cycle write", bus.mem_wraddress, wa);
      if (hold && c == last + 2) chk("mem_wraddress resumed write", bus.mem_wraddress, wa2);
      k = (c - 2 < ln - 1) ? c - 2 : ln - 1;
      ra = (ln == 0 || c < 2) ? last_rd : b + A'(k);
      chk("mem_rdaddress", bus.mem_rdaddress, ra);
      if (hold && c == last + 1) begin
        wa2 = ref_ptr;
        model_wr(1'b0, '0, wd);
      end
      if (c == last + 2) bus.wr_valid = 1'b0;
      else tick();
    end
    chk("all words emitted", ec.size(), 0);
    if (ln != 0) last_rd = b + A'(ln - 1);
    drive_idle();
  endtask
  task automatic rand_writes;
    int n;
    n = $urandom_range(0, 20);
    put(1'b1, A'($urandom), W'($urandom));
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.wr_valid = 1'b0;
        bus.wr_load = 1'b0;
        tick();
      end
      put(1'b0, '0, W'($urandom));
    end
    drive_idle();
    tick();
  endtask
  initial begin
    int cnt;
    tbl[0] = '{1'b1, 10'h3FE, 1'b0, 16'h0000, 1'b0, 10'h000};
    tbl[1] = '{1'b0, 10'h000, 1'b1, 16'hA11A, 1'b1, 10'h3FE};
    tbl[2] = '{1'b0, 10'h000, 1'b1, 16'hB22B, 1'b1, 10'h3FF};
    tbl[3] = '{1'b0, 10'h000, 1'b1, 16'hC33C, 1'b1, 10'h000};
    tbl[4] = '{1'b0, 10'h000, 1'b1, 16'hD44D, 1'b1, 10'h001};
    tbl[5] = '{1'b1, 10'h100, 1'b1, 16'hE55E, 1'b1, 10'h100};
    tbl[6] = '{1'b0, 10'h000, 1'b1, 16'hF66F, 1'b1, 10'h101};
    tbl[7] = '{1'b0, 10'h000, 1'b0, 16'h0000, 1'b0, 10'h000};
    drive_idle();
    bus.wr_data = '0;
    bus.wr_base = '0;
    bus.rd_base = '0;
    bus.rd_len = '0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    #3 rst_n = 1'b1;
    tick();
    chk("wr_ready after reset", bus.wr_ready, 1);
    put(1'b1, '0, W'($urandom));
    for (int i = 1; i < D; i++) put(1'b0, '0, W'($urandom));
    drive_idle();
    tick();
    for (int i = 0; i < 8; i++) begin
      bus.wr_load = tbl[i].ld;
      bus.wr_base = tbl[i].b;
      bus.wr_valid = tbl[i].v;
      bus.wr_data = tbl[i].d;
      if (tbl[i].v) model_wr(tbl[i].ld, tbl[i].b, tbl[i].d);
      else if (tbl[i].ld) ref_ptr = tbl[i].b;
      tick();
      chk($sformatf("vec%0d mem_wren", i), bus.mem_wren, tbl[i].e_wren);
      if (tbl[i].e_wren) begin
        chk($sformatf("vec%0d mem_wraddress", i), bus.mem_wraddress, tbl[i].e_addr);
        chk($sformatf("vec%0d mem_data", i), bus.mem_data, tbl[i].d);
      end
    end
    drive_idle();
    tick();
    put(1'b1, '0, {W'($urandom) & ~W'(1)} | W'(1));
    for (int i = 1; i < 16; i++) put(1'b0, '0, (W'($urandom) & ~W'(1)) | W'(i % 2 == 0));
    drive_idle();
    tick();
    scan('0, 16, 0, 0, '0);
    tick();
    scan('0, 20, 0, 0, '0);
    tick();
    scan(10'h055, 0, 0, 0, '0);
    tick();
    bus.wr_load = 1'b1;
    bus.wr_base = 10'd5;
    ref_ptr = 10'd5;
    tick();
    drive_idle();
    scan('0, 20, 1, 1, (W'($urandom) & ~W'(1)) | W'(~ref_mem[5][0]));
    tick();
    bus.rd_start = 1'b1;
    bus.rd_base = '0;
    bus.rd_len = 11'd40;
    tick();
    bus.rd_start = 1'b0;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("mid-scan reset");
    ref_ptr = '0;
    last_rd = '0;
    tick();
    tick();
    #3 rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (bus.rd_out_valid || bus.rd_done || bus.rd_busy) cnt++;
    end
    chk("no scan activity after reset", cnt, 0);
    scan(10'h3F8, 24, 0, 0, '0);
    tick();
    for (int r = 0; r < 6; r++) begin
      rand_writes();
      scan((r % 2 == 0) ? A'(10'h3F0 + $urandom_range(0, 15)) : A'($urandom), $urandom_range(1, 48), r % 3 == 0, r % 3 == 0, W'($urandom));
      tick();
    end
    scan(10'h200, D, 0, 0, '0);
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
